chaos_entropy_sampler: RTL and testbench
========================================

Name: chaos_entropy_sampler

Overview:
Digital back-end for the tiny-chaos analog core. It samples the comparator bit produced by the chaotic oscillator and removes bias with a von Neumann extractor. It packs the debiased bits into bytes, buffers them in a small FIFO, and presents them on a pop handshake for the top-level digital pins. A repetition-count health test flags a stuck or dead oscillator.

Parameters:
SAMPLE_DIV, 16, clocks between raw samples (>=2); counter width $clog2(SAMPLE_DIV)
REP_LIMIT, 32, consecutive identical raw samples that trip the health test (>=2)
FIFO_DEPTH, 4, byte FIFO entries (power of two)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
chaos_in  in  1  raw comparator bit from the analog core, asynchronous to clk
en  in  1  sampling enable; low clears the pipeline state and the health state
rd_ack  in  1  single-cycle pop of the FIFO head
data_out  out  8  FIFO head byte; 0 when empty
data_valid  out  1  FIFO not empty
fifo_full  out  1  FIFO holds FIFO_DEPTH bytes
overflow  out  1  sticky: a completed byte was dropped because the FIFO was full
health_fail  out  1  sticky: repetition test tripped
raw_sync  out  1  synchronized raw bit, for debug

Behaviour:
- Reset: every register is 0, so all outputs are 0, the FIFO is empty, and the divider, pair, bit and run counters are 0.
- Synchronizer: 2-FF on chaos_in. raw_sync is the second flop.
- Divider: counts 0..SAMPLE_DIV-1 while en=1; the sample strobe fires when count==SAMPLE_DIV-1, then the count wraps to 0.
- en=0 effects, each in one cycle:
  - divider held at 0;
  - pair-half flag, shift register and bit count cleared, so a partial byte is discarded;
  - run counter and health_fail cleared.
  - FIFO contents and overflow are unaffected.
- Von Neumann stage, on each strobe:
  - If no first sample is held, store raw_sync as the first sample.
  - Otherwise compare. Samples differ: emit bit = first sample. Samples equal: emit nothing. Either way the pair flag clears.
- Byte packing, first emitted bit ends at the MSB:
  - An emitted bit shifts in: shift <= {shift[6:0], bit}, bitcnt++.
  - On the 8th bit, at the same clock edge, byte {shift[6:0], bit} is pushed and bitcnt wraps to 0.
  - data_valid rises the following cycle when the FIFO was empty.
- FIFO:
  - rd_ack with data_valid=1 pops the head. rd_ack while empty is ignored.
  - Push and pop in the same cycle are both performed, including when the FIFO is full, so no overflow in that case.
  - A push to a full FIFO with no pop drops the byte and sets overflow.
  - overflow clears on the next accepted pop.
- Health test:
  - The run counter counts consecutive identical raw samples at strobes; it resets to 1 on a change and saturates at REP_LIMIT.
  - When it reaches REP_LIMIT, health_fail is set at that strobe edge.
  - While health_fail=1, emitted bits are discarded and nothing is pushed. Existing FIFO bytes stay readable.
- Reset mid-operation is asynchronous: all state returns to reset values immediately, with no partial byte retained.

Decomposition:
- Package chaos_pkg holds the default SAMPLE_DIV, REP_LIMIT and FIFO_DEPTH constants, the byte width (8) and a pointer-width function.
- One natural sub-module, entropy_fifo: synchronous FIFO with push, pop, full, empty and head-data outputs, parameterized by depth.
- The synchronizer, divider, extractor, packer and health logic stay in the top module.

Test Plan:
1. Reset and idle: hold rst_n low, then release with en=0 and chaos_in toggling -> all outputs stay 0 apart from raw_sync, which follows chaos_in 2 cycles later; divider stays at 0.
2. Debias packing: en=1, SAMPLE_DIV=16, drive raw pairs (1,0),(0,1) repeated 4 times, stable over each strobe -> data_out=0xAA with data_valid=1 one cycle after the 16th strobe.
3. Equal pairs discarded: interleave (0,0) and (1,1) pairs with eight (0,1) pairs -> exactly one byte, 0x00; equal pairs add no bits.
4. Health trip: chaos_in held at 1 for 32 strobes -> health_fail=1 at the 32nd strobe edge. Subsequent valid (1,0) pairs push nothing; toggling en low for 1 cycle clears health_fail.
5. Overflow: produce 5 bytes with no rd_ack -> fifo_full=1 after the 4th and overflow=1 after the 5th. Four rd_acks then return bytes 1–4 in order; overflow clears on the first pop; data_valid drops after the 4th.
6. Mid-byte abort: emit 5 bits, drop en for 1 cycle, re-enable, then emit 8 bits of pattern 0xC3 -> FIFO holds only 0xC3. Repeat with rst_n pulsed mid-byte -> FIFO empty and all flags 0.

Source files
------------

// File: rtl/chaos_pkg.sv
// chaos_pkg: shared defaults and helpers for the chaos entropy sampler
package chaos_pkg;

    localparam int SAMPLE_DIV_DEF = 16;
    localparam int REP_LIMIT_DEF  = 32;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int BYTE_W         = 8;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/entropy_fifo.sv
// entropy_fifo: small synchronous byte FIFO; head reads 0 when empty
module entropy_fifo
    import chaos_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [BYTE_W-1:0] head
);

    localparam int AW = ptr_w(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              pop_ok;
    logic              push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : mem[rd_ptr];

    // storage, pointers and occupancy; a pop frees a slot for a same-cycle push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/chaos_entropy_sampler.sv
// chaos_entropy_sampler: samples the chaos comparator, debiases, packs bytes and runs a repetition health test
module chaos_entropy_sampler
    import chaos_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int REP_LIMIT  = REP_LIMIT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              chaos_in,
    input  logic              en,
    input  logic              rd_ack,
    output logic [BYTE_W-1:0] data_out,
    output logic              data_valid,
    output logic              fifo_full,
    output logic              overflow,
    output logic              health_fail,
    output logic              raw_sync
);

    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam int CW = $clog2(BYTE_W);

    logic              sync0;
    logic [DW-1:0]     div_cnt;
    logic              have_first;
    logic              first_smp;
    logic [BYTE_W-2:0] shift;
    logic [CW-1:0]     bit_cnt;
    logic [RW-1:0]     run_cnt;
    logic [RW-1:0]     run_next;
    logic              last_smp;
    logic              strobe;
    logic              emit;
    logic              take;
    logic              push;
    logic              pop_ok;
    logic              drop;
    logic              fifo_empty;

    assign strobe     = en && (div_cnt == DW'(SAMPLE_DIV - 1));
    assign emit       = strobe && have_first && (first_smp != raw_sync);
    assign take       = emit && !health_fail;
    assign push       = take && (bit_cnt == CW'(BYTE_W - 1));
    assign data_valid = !fifo_empty;
    assign pop_ok     = rd_ack && data_valid;
    assign drop       = push && fifo_full && !pop_ok;

    // run length of identical samples, restarting at 1 on a change and saturating at the limit
    always_comb begin
        run_next = (run_cnt == '0 || raw_sync != last_smp) ? RW'(1) :
                   (run_cnt == RW'(REP_LIMIT))             ? run_cnt : run_cnt + 1'b1;
    end

    // two-flop synchronizer for the asynchronous comparator bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0    <= 1'b0;
            raw_sync <= 1'b0;
        end else begin
            sync0    <= chaos_in;
            raw_sync <= sync0;
        end
    end

    // sample divider, parked at 0 while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt <= '0;
        else if (!en || strobe) div_cnt <= '0;
        else div_cnt <= div_cnt + 1'b1;
    end

    // von Neumann pairing and MSB-first byte packing; disabling drops any partial byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_first <= 1'b0;
            first_smp  <= 1'b0;
            shift      <= '0;
            bit_cnt    <= '0;
        end else if (!en) begin
            have_first <= 1'b0;
            shift      <= '0;
            bit_cnt    <= '0;
        end else if (strobe) begin
            have_first <= !have_first;
            if (!have_first) first_smp <= raw_sync;
            if (take) begin
                shift   <= {shift[BYTE_W-3:0], first_smp};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // repetition-count health test with a sticky failure flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt     <= '0;
            last_smp    <= 1'b0;
            health_fail <= 1'b0;
        end else if (!en) begin
            run_cnt     <= '0;
            last_smp    <= 1'b0;
            health_fail <= 1'b0;
        end else if (strobe) begin
            run_cnt  <= run_next;
            last_smp <= raw_sync;
            if (run_next == RW'(REP_LIMIT)) health_fail <= 1'b1;
        end
    end

    // sticky overflow on a dropped byte, cleared by the next accepted pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow <= 1'b0;
        else if (pop_ok) overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

    entropy_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({shift, first_smp}),
        .pop       (rd_ack),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (data_out)
    );

endmodule

// File: tb/tb_chaos_entropy_sampler.sv
// tb_chaos_entropy_sampler: scoreboard bench for the chaos entropy sampler
module tb_chaos_entropy_sampler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       chaos_in = 1'b0;
    logic       en = 1'b0;
    logic       rd_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       fifo_full;
    logic       overflow;
    logic       health_fail;
    logic       raw_sync;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    logic       m_have, m_first, m_last, m_hf;
    logic [7:0] m_sh;
    int         m_cnt, m_run;

    chaos_entropy_sampler #(.SAMPLE_DIV(16), .REP_LIMIT(32), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .chaos_in    (chaos_in),
        .en          (en),
        .rd_ack      (rd_ack),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .fifo_full   (fifo_full),
        .overflow    (overflow),
        .health_fail (health_fail),
        .raw_sync    (raw_sync)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_have = 0; m_first = 0; m_last = 0; m_hf = 0; m_sh = 0; m_cnt = 0; m_run = 0;
    endtask

    task automatic scoreboard_compare(input string tag);
        logic [7:0] e;
        e = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        checks++;
        if (data_out !== e || data_valid !== (exp_q.size() != 0) || fifo_full !== (exp_q.size() == 4) ||
            overflow !== exp_ovf || health_fail !== m_hf) begin
            errors++;
            $display("FAIL %s got data=%h valid=%b full=%b ovf=%b hf=%b exp data=%h valid=%b full=%b ovf=%b hf=%b",
                     tag, data_out, data_valid, fifo_full, overflow, health_fail,
                     e, exp_q.size() != 0, exp_q.size() == 4, exp_ovf, m_hf);
        end
    endtask

    task automatic sample(input logic b, input logic do_pop);
        logic       emit, bt;
        logic [7:0] nb;
        chaos_in = b;
        repeat (15) tick();
        if (do_pop) rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        if (do_pop && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            exp_ovf = 0;
        end
        emit = m_have && (m_first != b);
        bt   = m_first;
        if (!m_have) begin m_have = 1; m_first = b; end else m_have = 0;
        if (emit && !m_hf) begin
            nb   = {m_sh[6:0], bt};
            m_sh = nb;
            if (m_cnt == 7) begin
                m_cnt = 0;
                if (exp_q.size() < 4) exp_q.push_back(nb); else exp_ovf = 1;
            end else m_cnt++;
        end
        if (m_run == 0 || b != m_last) m_run = 1; else if (m_run < 32) m_run++;
        m_last = b;
        if (m_run == 32) m_hf = 1;
        scoreboard_compare("strobe");
    endtask

    task automatic emit_bits(input logic [7:0] v, input int n, input logic pop_last);
        for (int i = 0; i < n; i++) begin
            sample(v[7-i], 1'b0);
            sample(~v[7-i], pop_last && (i == n - 1));
        end
    endtask

    task automatic en_off();
        en = 1'b0;
        tick();
        model_clear();
    endtask

    task automatic pop_one();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            exp_ovf = 0;
        end
        scoreboard_compare("pop");
    endtask

    task automatic test_reset();
        model_clear();
        repeat (3) tick();
        checks++;
        if ({data_out, data_valid, fifo_full, overflow, health_fail, raw_sync} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {data_out, data_valid, fifo_full, overflow, health_fail, raw_sync});
        end
        rst_n = 1'b1;
        chaos_in = 1'b1;
        tick();
        checks++;
        if (raw_sync !== 1'b0) begin errors++; $display("FAIL sync_lat1 got %b exp 0", raw_sync); end
        tick();
        checks++;
        if (raw_sync !== 1'b1) begin errors++; $display("FAIL sync_rise got %b exp 1", raw_sync); end
        chaos_in = 1'b0;
        tick();
        checks++;
        if (raw_sync !== 1'b1) begin errors++; $display("FAIL sync_lat2 got %b exp 1", raw_sync); end
        tick();
        checks++;
        if (raw_sync !== 1'b0) begin errors++; $display("FAIL sync_fall got %b exp 0", raw_sync); end
        checks++;
        if (dut.div_cnt !== '0) begin errors++; $display("FAIL idle_div got %0d exp 0", dut.div_cnt); end
        scoreboard_compare("idle");
    endtask

    task automatic test_debias();
        en = 1'b1;
        emit_bits(8'hAA, 8, 1'b0);
        checks++;
        if (data_out !== 8'hAA || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL debias_byte got %h/%b exp aa/1", data_out, data_valid);
        end
        en_off();
        pop_one();
    endtask

    task automatic test_equal_pairs();
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample(i[0], 1'b0);
            sample(i[0], 1'b0);
            sample(1'b0, 1'b0);
            sample(1'b1, 1'b0);
        end
        checks++;
        if (data_out !== 8'h00 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL equal_pairs got %h/%b exp 00/1", data_out, data_valid);
        end
        en_off();
        pop_one();
        pop_one();
    endtask

    task automatic test_health();
        en = 1'b1;
        repeat (31) sample(1'b1, 1'b0);
        checks++;
        if (health_fail !== 1'b0) begin errors++; $display("FAIL health_early got %b exp 0", health_fail); end
        sample(1'b1, 1'b0);
        checks++;
        if (health_fail !== 1'b1) begin errors++; $display("FAIL health_trip got %b exp 1", health_fail); end
        emit_bits(8'hFF, 8, 1'b0);
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL health_block got %b exp 0", data_valid); end
        en_off();
        checks++;
        if (health_fail !== 1'b0) begin errors++; $display("FAIL health_clear got %b exp 0", health_fail); end
    endtask

    task automatic test_overflow();
        en = 1'b1;
        emit_bits(8'h11, 8, 1'b0);
        emit_bits(8'h22, 8, 1'b0);
        emit_bits(8'h33, 8, 1'b0);
        emit_bits(8'h44, 8, 1'b0);
        checks++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_4 got full=%b ovf=%b exp 1/0", fifo_full, overflow);
        end
        emit_bits(8'h55, 8, 1'b0);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_5 got %b exp 1", overflow); end
        en_off();
        repeat (4) pop_one();
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL drained got %b exp 0", data_valid); end
        en = 1'b1;
        emit_bits(8'h66, 8, 1'b0);
        emit_bits(8'h77, 8, 1'b0);
        emit_bits(8'h88, 8, 1'b0);
        emit_bits(8'h99, 8, 1'b0);
        emit_bits(8'hAB, 8, 1'b1);
        checks++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0 || data_out !== 8'h77) begin
            errors++;
            $display("FAIL push_pop_full got full=%b ovf=%b head=%h exp 1/0/77", fifo_full, overflow, data_out);
        end
        en_off();
        repeat (4) pop_one();
    endtask

    task automatic test_abort();
        en = 1'b1;
        emit_bits(8'hB0, 5, 1'b0);
        en_off();
        en = 1'b1;
        emit_bits(8'hC3, 8, 1'b0);
        en_off();
        checks++;
        if (data_out !== 8'hC3 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL abort_en got %h exp c3", data_out);
        end
        pop_one();
        en = 1'b1;
        emit_bits(8'h5A, 8, 1'b0);
        emit_bits(8'hE8, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({data_out, data_valid, fifo_full, overflow, health_fail, raw_sync} !== 13'd0) begin
            errors++;
            $display("FAIL abort_rst got %h exp 0", {data_out, data_valid, fifo_full, overflow, health_fail, raw_sync});
        end
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        exp_ovf = 0;
        model_clear();
        tick();
        scoreboard_compare("after_rst");
        checks++;
        if (dut.bit_cnt !== '0) begin errors++; $display("FAIL rst_bitcnt got %0d exp 0", dut.bit_cnt); end
    endtask

    initial begin
        test_reset();
        test_debias();
        test_equal_pairs();
        test_health();
        test_overflow();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
